icache_fill_ctrl: RTL and testbench
===================================

# icache_fill_ctrl

Single-clock sequencer for the instruction cache's fill and flush ports. On a miss it fetches one line from memory as 32-bit beats, assembles it, and writes it into the cache data/tag arrays in a single fill cycle. On a flush request it sweeps every cache index and clears its valid bit. Flush and miss service share the cache write ports, and this block is the only writer of them.

## Interface
- LOG2CACHELINESIZE, 7: line size in bits, log2. Legal range 6..9. Line = 2**LOG2CACHELINESIZE bits.
- LOG2CACHEDEPTH, 6: number of cache lines, log2.
- BEATS, derived, 2**(LOG2CACHELINESIZE-5): 32-bit memory beats per line (4 by default).

Ports:
- clk  in  1  clock; the only clock.
- resetn  in  1  reset; synchronous, active-low.
- miss_valid  in  1  cache reports a miss; held until serviced.
- miss_addr  in  32  byte address of the missing word.
- flush_req  in  1  single-cycle pulse requesting a full invalidate.
- mem_rd_req  out  1  line read request; held until accepted.
- mem_rd_addr  out  32  line-aligned byte address of the request.
- mem_rd_accept  in  1  memory accepts the request this cycle.
- mem_rdata_valid  in  1  one beat of read data is present this cycle.
- mem_rdata  in  32  beat data, in ascending address order.
- fill_we  out  1  write the line, tag and valid=1 into the cache.
- fill_addr  out  32  line-aligned address for the fill.
- fill_data  out  2**LOG2CACHELINESIZE  assembled line.
- inv_we  out  1  clear the valid bit at inv_idx.
- inv_idx  out  LOG2CACHEDEPTH  index being invalidated.
- miss_done  out  1  pulse; the line is now resident.
- flush_done  out  1  pulse; the final index has been invalidated.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FLUSH, REQ, BEAT, FILL, SETTLE. All outputs are registered.
- Reset: state goes to IDLE, the flush pending flag and counters clear, and every output is 0. Reset does not invalidate the arrays; software must issue a flush after reset.
- A flush_req seen in any state other than FLUSH sets flush_pend. A flush_req seen in FLUSH also sets flush_pend, which causes one further complete sweep after the current one.
- IDLE priority: flush_pend or flush_req first, then miss_valid.
  - Entering FLUSH clears flush_pend.
  - Entering REQ latches line_addr = miss_addr with bits [LOG2CACHELINESIZE-4:0] cleared.
- FLUSH
  - inv_we=1 for exactly 2**LOG2CACHEDEPTH consecutive cycles.
  - inv_idx counts 0, 1, ... up to the maximum index, then wraps to 0 on exit.
  - flush_done=1 in the same cycle as the last index.
  - Next state is IDLE.
- REQ
  - mem_rd_req=1 and mem_rd_addr=line_addr.
  - On mem_rd_accept, go to BEAT with beat_cnt=0.
  - mem_rd_req drops in the cycle after acceptance.
- BEAT
  - Each mem_rdata_valid cycle writes mem_rdata into fill_data lane beat_cnt, bits [32*beat_cnt+31 : 32*beat_cnt], and increments beat_cnt.
  - The cycle that carries beat BEATS-1 moves the state to FILL.
  - Cycles without mem_rdata_valid hold state.
- FILL
  - One cycle with fill_we=1, fill_addr=line_addr, fill_data=the assembled line, and miss_done=1.
  - Next state is SETTLE.
- SETTLE: one idle cycle so the cache re-looks up the address before miss_valid is sampled again. Next state is IDLE.
- A miss or flush is never aborted once started.
- mem_rdata_valid and mem_rd_accept are ignored outside BEAT and REQ respectively.
- fill_we and inv_we are never high in the same cycle.
- fill_data holds its value between fills.

## Timing
- Miss latency, from the miss being sampled in IDLE to fill_we: 1 cycle (IDLE→REQ) + accept wait + beat cycles + 1.
  - With same-cycle accept and back-to-back beats, fill_we rises 2+BEATS cycles after IDLE sampled miss_valid, which is 6 cycles for the default parameters.
- Flush duration: 2**LOG2CACHEDEPTH cycles of inv_we, plus 1 IDLE cycle before the next action.
- busy rises in the cycle after IDLE accepts work. It falls when the state returns to IDLE, which is the cycle after SETTLE or the cycle after the last flush index.
- Reset is checked ahead of every state transition. Asserting resetn=0 mid-BEAT discards any partial line, and no fill_we occurs.

## Test plan
- Reset, then miss_valid=1 with miss_addr=0x00001234; memory accepts immediately and returns 0xA0, 0xA1, 0xA2, 0xA3 back-to-back.
  - Expect mem_rd_addr=0x00001230.
  - Expect one fill_we with fill_addr=0x00001230 and fill_data=0x000000A3_000000A2_000000A1_000000A0.
  - Expect miss_done in the same cycle.
- flush_req pulse while idle.
  - Expect inv_we for exactly 64 cycles with inv_idx 0..63, flush_done coincident with idx 63, and busy low on the next cycle.
- flush_req during BEAT.
  - Expect the fill to complete unchanged, then SETTLE, then a full 64-cycle flush with no fill_we inside it.
- Memory delays accept by 3 cycles and inserts a 2-cycle gap between beats 1 and 2.
  - Expect mem_rd_req held for 4 cycles, no lane corruption, and fill_we exactly once.
- resetn=0 after beat 1, then miss_valid held.
  - Expect all outputs at 0 during reset.
  - Expect no fill_we before a fresh mem_rd_req.
  - Expect beats to be reassembled from lane 0.
- flush_req and miss_valid asserted in the same IDLE cycle.
  - Expect the flush to run first, then mem_rd_req.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill/flush sequencer: fetches a missing line as 32-bit beats and writes it in
// one cycle, or sweeps every index clearing its valid bit. Sole owner of the cache write ports.
module icache_fill_ctrl #(
   parameter int unsigned LOG2CACHELINESIZE = 7,
   parameter int unsigned LOG2CACHEDEPTH    = 6
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              miss_valid,
   input  logic [31:0]                       miss_addr,
   input  logic                              flush_req,
   output logic                              mem_rd_req,
   output logic [31:0]                       mem_rd_addr,
   input  logic                              mem_rd_accept,
   input  logic                              mem_rdata_valid,
   input  logic [31:0]                       mem_rdata,
   output logic                              fill_we,
   output logic [31:0]                       fill_addr,
   output logic [2**LOG2CACHELINESIZE-1:0]   fill_data,
   output logic                              inv_we,
   output logic [LOG2CACHEDEPTH-1:0]         inv_idx,
   output logic                              miss_done,
   output logic                              flush_done,
   output logic                              busy
);

   localparam int unsigned LineBits = 2 ** LOG2CACHELINESIZE;
   localparam int unsigned BeatCntW = LOG2CACHELINESIZE - 5;
   localparam int unsigned Beats    = 2 ** BeatCntW;
   localparam int unsigned OffsetW  = LOG2CACHELINESIZE - 3;

   localparam logic [31:0]               OffsetMask = 32'((64'd1 << OffsetW) - 64'd1);
   localparam logic [LOG2CACHEDEPTH-1:0] IdxMax     = '1;
   localparam logic [BeatCntW-1:0]       BeatMax    = BeatCntW'(Beats - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFlush,
      StReq,
      StBeat,
      StFill,
      StSettle
   } state_e;

   state_e                    state_q, state_d;
   logic                      flush_pend_q, flush_pend_d;
   logic [31:0]               line_addr_q, line_addr_d;
   logic [BeatCntW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [LOG2CACHEDEPTH-1:0] flush_cnt_q, flush_cnt_d;
   logic [LineBits-1:0]       fill_data_q, fill_data_d;

   logic mem_rd_req_q, mem_rd_req_d;
   logic fill_we_q, fill_we_d;
   logic inv_we_q, inv_we_d;
   logic miss_done_q, miss_done_d;
   logic flush_done_q, flush_done_d;
   logic busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= StIdle;
         flush_pend_q <= 1'b0;
         line_addr_q  <= '0;
         beat_cnt_q   <= '0;
         flush_cnt_q  <= '0;
         fill_data_q  <= '0;
         mem_rd_req_q <= 1'b0;
         fill_we_q    <= 1'b0;
         inv_we_q     <= 1'b0;
         miss_done_q  <= 1'b0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         line_addr_q  <= line_addr_d;
         beat_cnt_q   <= beat_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         fill_data_q  <= fill_data_d;
         mem_rd_req_q <= mem_rd_req_d;
         fill_we_q    <= fill_we_d;
         inv_we_q     <= inv_we_d;
         miss_done_q  <= miss_done_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
      end
   end

   // Flush work outranks a miss whenever both are visible in IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (flush_pend_q || flush_req) begin
               state_d = StFlush;
            end else if (miss_valid) begin
               state_d = StReq;
            end
         end
         StFlush: begin
            if (flush_cnt_q == IdxMax) begin
               state_d = StIdle;
            end
         end
         StReq: begin
            if (mem_rd_accept) begin
               state_d = StBeat;
            end
         end
         StBeat: begin
            if (mem_rdata_valid && (beat_cnt_q == BeatMax)) begin
               state_d = StFill;
            end
         end
         StFill:   state_d = StSettle;
         StSettle: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_comb begin
      flush_pend_d = flush_pend_q;
      line_addr_d  = line_addr_q;
      beat_cnt_d   = beat_cnt_q;
      flush_cnt_d  = '0;
      fill_data_d  = fill_data_q;

      if ((state_q == StIdle) && (state_d == StFlush)) begin
         flush_pend_d = 1'b0;
      end else if (flush_req) begin
         flush_pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (state_d == StReq) begin
               line_addr_d = miss_addr & ~OffsetMask;
            end
         end
         StFlush: flush_cnt_d = flush_cnt_q + LOG2CACHEDEPTH'(1);
         StReq:   beat_cnt_d  = '0;
         StBeat: begin
            if (mem_rdata_valid) begin
               fill_data_d[{beat_cnt_q, 5'd0} +: 32] = mem_rdata;
               beat_cnt_d = beat_cnt_q + BeatCntW'(1);
            end
         end
         default: ;
      endcase

      mem_rd_req_d = (state_d == StReq);
      fill_we_d    = (state_d == StFill);
      miss_done_d  = (state_d == StFill);
      inv_we_d     = (state_d == StFlush);
      flush_done_d = (state_d == StFlush) && (flush_cnt_d == IdxMax);
      busy_d       = (state_d != StIdle);
   end

   assign mem_rd_req  = mem_rd_req_q;
   assign mem_rd_addr = line_addr_q;
   assign fill_we     = fill_we_q;
   assign fill_addr   = line_addr_q;
   assign fill_data   = fill_data_q;
   assign inv_we      = inv_we_q;
   assign inv_idx     = flush_cnt_q;
   assign miss_done   = miss_done_q;
   assign flush_done  = flush_done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: cycle tables, directed corner sequences and a randomized run
// scored against a transaction-level model of misses, memory beats and flush sweeps.
module tb_icache_fill_ctrl;

   localparam int unsigned L2Line     = 7;
   localparam int unsigned L2Depth    = 6;
   localparam int          Sweep      = 64;
   localparam int          RndCycles  = 3000;
   localparam int          DrainMax   = 600;

   logic         clk = 1'b0;
   logic         resetn;
   logic         miss_valid;
   logic [31:0]  miss_addr;
   logic         flush_req;
   logic         mem_rd_req;
   logic [31:0]  mem_rd_addr;
   logic         mem_rd_accept;
   logic         mem_rdata_valid;
   logic [31:0]  mem_rdata;
   logic         fill_we;
   logic [31:0]  fill_addr;
   logic [127:0] fill_data;
   logic         inv_we;
   logic [5:0]   inv_idx;
   logic         miss_done;
   logic         flush_done;
   logic         busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   icache_fill_ctrl #(
      .LOG2CACHELINESIZE(L2Line),
      .LOG2CACHEDEPTH   (L2Depth)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .miss_valid     (miss_valid),
      .miss_addr      (miss_addr),
      .flush_req      (flush_req),
      .mem_rd_req     (mem_rd_req),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_accept  (mem_rd_accept),
      .mem_rdata_valid(mem_rdata_valid),
      .mem_rdata      (mem_rdata),
      .fill_we        (fill_we),
      .fill_addr      (fill_addr),
      .fill_data      (fill_data),
      .inv_we         (inv_we),
      .inv_idx        (inv_idx),
      .miss_done      (miss_done),
      .flush_done     (flush_done),
      .busy           (busy)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, want %0b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic mv, input logic [31:0] addr, input logic fr,
                         input logic acc, input logic rv, input logic [31:0] rd);
      miss_valid      = mv;
      miss_addr       = addr;
      flush_req       = fr;
      mem_rd_accept   = acc;
      mem_rdata_valid = rv;
      mem_rdata       = rd;
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_req"}, mem_rd_req, 1'b0);
      chk1({tag, "_fwe"}, fill_we, 1'b0);
      chk1({tag, "_inv"}, inv_we, 1'b0);
      chk1({tag, "_mdone"}, miss_done, 1'b0);
      chk1({tag, "_fdone"}, flush_done, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chkw({tag, "_rdaddr"}, 128'(mem_rd_addr), 128'(0));
      chkw({tag, "_faddr"}, 128'(fill_addr), 128'(0));
      chkw({tag, "_fdata"}, fill_data, 128'(0));
      chkw({tag, "_idx"}, 128'(inv_idx), 128'(0));
   endtask

   // Called just after the edge that entered the sweep; returns just after the edge leaving it.
   task automatic check_sweep(input string tag);
      for (int i = 0; i < Sweep; i++) begin
         chk1({tag, "_inv_we"}, inv_we, 1'b1);
         chkw({tag, "_inv_idx"}, 128'(inv_idx), 128'(i));
         chk1({tag, "_flush_done"}, flush_done, (i == Sweep - 1));
         chk1({tag, "_no_fill"}, fill_we, 1'b0);
         chk1({tag, "_busy"}, busy, 1'b1);
         tick();
      end
      chk1({tag, "_end_inv"}, inv_we, 1'b0);
      chk1({tag, "_end_busy"}, busy, 1'b0);
      chkw({tag, "_end_idx"}, 128'(inv_idx), 128'(0));
   endtask

   // Drives a full miss from REQ onward with immediate accept and back-to-back beats.
   task automatic run_miss(input string tag, input logic [31:0] addr, input logic [127:0] line);
      set_in(1'b1, addr, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      chk1({tag, "_req_drop"}, mem_rd_req, 1'b0);
      for (int b = 0; b < 4; b++) begin
         set_in(1'b1, addr, 1'b0, 1'b0, 1'b1, line[32*b +: 32]);
         tick();
         chk1({tag, "_fwe"}, fill_we, (b == 3));
      end
      chkw({tag, "_faddr"}, 128'(fill_addr), 128'(addr & 32'hFFFF_FFF0));
      chkw({tag, "_fdata"}, fill_data, line);
      chk1({tag, "_mdone"}, miss_done, 1'b1);
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk1({tag, "_settle_busy"}, busy, 1'b1);
      chk1({tag, "_settle_fwe"}, fill_we, 1'b0);
      tick();
      chk1({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   typedef struct {
      logic         mv;
      logic [31:0]  addr;
      logic         acc;
      logic         rv;
      logic [31:0]  rd;
      logic         e_req;
      logic         e_fwe;
      logic         e_busy;
      logic [31:0]  e_addr;
      logic [127:0] e_line;
   } vec_t;

   function automatic vec_t mkv(input logic mv, input logic [31:0] addr, input logic acc,
                                input logic rv, input logic [31:0] rd, input logic e_req,
                                input logic e_fwe, input logic e_busy, input logic [31:0] e_addr,
                                input logic [127:0] e_line);
      vec_t v;
      v.mv = mv; v.addr = addr; v.acc = acc; v.rv = rv; v.rd = rd;
      v.e_req = e_req; v.e_fwe = e_fwe; v.e_busy = e_busy; v.e_addr = e_addr; v.e_line = e_line;
      return v;
   endfunction

   vec_t vecs[$];

   // Random-run model state
   logic         miss_active;
   logic [31:0]  cur_addr;
   logic [31:0]  exp_line_addr;
   logic [127:0] acc_line;
   int           beats_sent;
   int           mem_phase;
   logic         flush_uncov;
   int           sweep_pos;
   int           n_miss;
   int           n_fill;
   logic         prev_req;
   logic         acc_now;
   logic         last_beat_now;
   logic         allow_new;
   logic         drained;

   initial begin
      logic [127:0] l1, l2;
      l1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      l2 = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};

      // Immediate accept, back-to-back beats, then junk handshakes while idle.
      vecs.push_back(mkv(1, 32'h0000_1234, 0, 0, 32'h0, 1, 0, 1, 32'h0000_1230, '0));
      vecs.push_back(mkv(1, 32'h0000_1234, 1, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_1234, 0, 1, 32'hA0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_1234, 0, 1, 32'hA1, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_1234, 0, 1, 32'hA2, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_1234, 0, 1, 32'hA3, 0, 1, 1, 32'h0000_1230, l1));
      vecs.push_back(mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(0, 32'h0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, '0));
      vecs.push_back(mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, '0));
      // Accept delayed by three cycles, two-cycle gap between beats 1 and 2.
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 0, 32'h0, 1, 0, 1, 32'h0000_ABC0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 1, 32'h5555, 1, 0, 1, 32'h0000_ABC0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 0, 32'h0, 1, 0, 1, 32'h0000_ABC0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 0, 32'h0, 1, 0, 1, 32'h0000_ABC0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 1, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 1, l2[31:0], 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 1, 1, l2[63:32], 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 1, l2[95:64], 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(1, 32'h0000_ABCC, 0, 1, l2[127:96], 0, 1, 1, 32'h0000_ABC0, l2));
      vecs.push_back(mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 32'h0, '0));
      vecs.push_back(mkv(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, '0));

      resetn = 1'b0;
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      check_all_zero("reset");
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         set_in(v.mv, v.addr, 1'b0, v.acc, v.rv, v.rd);
         tick();
         chk1($sformatf("tbl%0d_req", i), mem_rd_req, v.e_req);
         chk1($sformatf("tbl%0d_fwe", i), fill_we, v.e_fwe);
         chk1($sformatf("tbl%0d_mdone", i), miss_done, v.e_fwe);
         chk1($sformatf("tbl%0d_busy", i), busy, v.e_busy);
         chk1($sformatf("tbl%0d_inv", i), inv_we, 1'b0);
         if (v.e_req) chkw($sformatf("tbl%0d_rdaddr", i), 128'(mem_rd_addr), 128'(v.e_addr));
         if (v.e_fwe) begin
            chkw($sformatf("tbl%0d_faddr", i), 128'(fill_addr), 128'(v.e_addr));
            chkw($sformatf("tbl%0d_fdata", i), fill_data, v.e_line);
         end
      end
      chkw("fill_data_held", fill_data, l2);

      // Flush from idle.
      set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_sweep("idle_flush");

      // Flush request arriving during BEAT waits for fill and SETTLE.
      set_in(1'b1, 32'h0000_2008, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk1("fib_req", mem_rd_req, 1'b1);
      set_in(1'b1, 32'h0000_2008, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      set_in(1'b1, 32'h0000_2008, 1'b1, 1'b0, 1'b1, 32'hE0);
      tick();
      for (int b = 1; b < 4; b++) begin
         set_in(1'b1, 32'h0000_2008, 1'b0, 1'b0, 1'b1, 32'hE0 + 32'(b));
         tick();
         chk1("fib_fwe", fill_we, (b == 3));
         chk1("fib_inv", inv_we, 1'b0);
      end
      chkw("fib_faddr", 128'(fill_addr), 128'(32'h0000_2000));
      chkw("fib_fdata", fill_data, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk1("fib_settle_busy", busy, 1'b1);
      chk1("fib_settle_inv", inv_we, 1'b0);
      tick();
      chk1("fib_idle_inv", inv_we, 1'b0);
      chk1("fib_idle_busy", busy, 1'b0);
      tick();
      check_sweep("fib_flush");
      tick();
      chk1("fib_single_sweep", inv_we, 1'b0);

      // Reset in the middle of BEAT discards the partial line.
      set_in(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chkw("rst_rdaddr", 128'(mem_rd_addr), 128'(32'h0000_3000));
      set_in(1'b1, 32'h0000_3004, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      set_in(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b1, 32'hC0);
      tick();
      set_in(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b1, 32'hC1);
      tick();
      resetn = 1'b0;
      set_in(1'b1, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check_all_zero("rst_mid");
      tick();
      check_all_zero("rst_hold");
      resetn = 1'b1;
      tick();
      chk1("rst_fresh_req", mem_rd_req, 1'b1);
      chk1("rst_no_fwe", fill_we, 1'b0);
      chkw("rst_fresh_addr", 128'(mem_rd_addr), 128'(32'h0000_3000));
      run_miss("rst_refill", 32'h0000_3004, {32'hD3, 32'hD2, 32'hD1, 32'hD0});

      // Flush and miss in the same idle cycle: flush first.
      set_in(1'b1, 32'h0000_4448, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      set_in(1'b1, 32'h0000_4448, 1'b0, 1'b0, 1'b0, 32'h0);
      chk1("both_no_req", mem_rd_req, 1'b0);
      check_sweep("both_flush");
      chk1("both_req_late", mem_rd_req, 1'b0);
      tick();
      chk1("both_req", mem_rd_req, 1'b1);
      chkw("both_rdaddr", 128'(mem_rd_addr), 128'(32'h0000_4440));
      run_miss("both_miss", 32'h0000_4448, {32'hF3, 32'hF2, 32'hF1, 32'hF0});

      // Randomized traffic against the transaction model.
      miss_active = 1'b0;
      cur_addr = 32'h0;
      exp_line_addr = 32'h0;
      acc_line = '0;
      beats_sent = 0;
      mem_phase = 0;
      flush_uncov = 1'b0;
      sweep_pos = -1;
      n_miss = 0;
      n_fill = 0;
      allow_new = 1'b1;
      drained = 1'b0;
      for (int c = 0; c < RndCycles + DrainMax; c++) begin
         if (c >= RndCycles) allow_new = 1'b0;
         if (!allow_new && !miss_active && !flush_uncov && (sweep_pos < 0) && (mem_phase == 0)
             && !busy) begin
            drained = 1'b1;
            break;
         end
         if (allow_new && !miss_active && ($urandom_range(0, 3) == 0)) begin
            miss_active = 1'b1;
            cur_addr = $urandom;
            exp_line_addr = cur_addr & 32'hFFFF_FFF0;
            n_miss++;
         end
         miss_valid = miss_active;
         miss_addr = miss_active ? cur_addr : $urandom;
         flush_req = allow_new && ($urandom_range(0, 149) == 0);
         if (flush_req) flush_uncov = 1'b1;
         prev_req = mem_rd_req;
         mem_rd_accept = 1'b0;
         mem_rdata_valid = 1'b0;
         mem_rdata = $urandom;
         last_beat_now = 1'b0;
         if (mem_phase == 0) begin
            if (mem_rd_req) begin
               if ($urandom_range(0, 2) == 0) begin
                  mem_rd_accept = 1'b1;
                  mem_phase = 1;
                  beats_sent = 0;
               end
            end else begin
               mem_rd_accept = ($urandom_range(0, 5) == 0);
            end
            mem_rdata_valid = ($urandom_range(0, 5) == 0);
         end else begin
            mem_rd_accept = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0) begin
               mem_rdata_valid = 1'b1;
               acc_line[32*beats_sent +: 32] = mem_rdata;
               beats_sent++;
               if (beats_sent == 4) begin
                  mem_phase = 0;
                  last_beat_now = 1'b1;
               end
            end
         end
         acc_now = mem_rd_accept;
         tick();

         chk1("rnd_excl", fill_we && inv_we, 1'b0);
         if (prev_req) chk1("rnd_req_hold", mem_rd_req, !acc_now);
         if (mem_rd_req) begin
            chk1("rnd_req_miss", miss_active, 1'b1);
            chkw("rnd_rdaddr", 128'(mem_rd_addr), 128'(exp_line_addr));
         end
         chk1("rnd_fill_time", fill_we, last_beat_now);
         chk1("rnd_mdone", miss_done, fill_we);
         if (fill_we) begin
            chkw("rnd_faddr", 128'(fill_addr), 128'(exp_line_addr));
            chkw("rnd_fdata", fill_data, acc_line);
            miss_active = 1'b0;
            n_fill++;
         end
         if (fill_we || inv_we || mem_rd_req) chk1("rnd_busy", busy, 1'b1);
         if (inv_we) begin
            if (sweep_pos < 0) begin
               chk1("rnd_sweep_cause", flush_uncov, 1'b1);
               flush_uncov = 1'b0;
               sweep_pos = 0;
            end else begin
               sweep_pos++;
            end
            chkw("rnd_idx", 128'(inv_idx), 128'(sweep_pos));
            chk1("rnd_fdone", flush_done, (sweep_pos == Sweep - 1));
            if (sweep_pos == Sweep - 1) sweep_pos = -1;
         end else begin
            chk1("rnd_sweep_gap", (sweep_pos < 0), 1'b1);
            chk1("rnd_fdone_idle", flush_done, 1'b0);
            sweep_pos = -1;
         end
      end
      chk1("rnd_drained", drained, 1'b1);
      chkw("rnd_fill_count", 128'(n_fill), 128'(n_miss));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
